// File: rtl/eigen_deflation_sequencer.sv
// Drives one find_eigen instance through NUM_EIG power-iteration/deflation
// passes, feeding each pass's deflated matrix back in as the next working matrix.
//
// Ports:
//   clk, rst           clock, async active-high reset
//   start, abort       run request (IDLE only), return-to-IDLE
//   scale              forwarded unchanged as fe_scale
//   cov_matrix         source matrix, captured on accepted start
//   fe_*               find_eigen handshake (level start, completion pulse, data)
//   eigenvalues        one entry per pass, index 0 = first pass
//   eigenvectors       column k = eigenvector of pass k
//   eig_count          passes completed
//   busy, done, error  status; done is a one-cycle pulse, error is sticky
module eigen_deflation_sequencer #(
  parameter int SIZE_N     = 8,
  parameter int NUM_EIG    = 4,
  parameter int GAP_CYCLES = 2,
  parameter int MAX_CYCLES = 65536,
  localparam int CW = $clog2(NUM_EIG + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [31:0]   scale,
  input  logic [63:0]   cov_matrix [SIZE_N][SIZE_N],
  output logic          fe_start,
  output logic [31:0]   fe_scale,
  output logic [63:0]   fe_cov_matrix [SIZE_N][SIZE_N],
  input  logic [63:0]   fe_eigenvalue [1][1],
  input  logic [63:0]   fe_eigenvector [SIZE_N][1],
  input  logic [63:0]   fe_cov_matrix_out [SIZE_N][SIZE_N],
  input  logic          fe_valid,
  output logic [63:0]   eigenvalues [NUM_EIG],
  output logic [63:0]   eigenvectors [SIZE_N][NUM_EIG],
  output logic [CW-1:0] eig_count,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam int WW = $clog2(MAX_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, RUN, CAPTURE, GAP, DONE
  } state_t;

  state_t        state;
  logic [WW-1:0] wd;
  logic [GW-1:0] gap_cnt;
  logic [63:0]   work [SIZE_N][SIZE_N];

  assign fe_scale      = scale;
  assign fe_cov_matrix = work;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      fe_start  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      eig_count <= '0;
      wd        <= '0;
      gap_cnt   <= '0;
      for (int k = 0; k < NUM_EIG; k++)
        eigenvalues[k] <= '0;
      for (int i = 0; i < SIZE_N; i++) begin
        for (int k = 0; k < NUM_EIG; k++)
          eigenvectors[i][k] <= '0;
        for (int j = 0; j < SIZE_N; j++)
          work[i][j] <= '0;
      end
    end else if (abort && state != IDLE) begin
      // results and error stay as they are
      state    <= IDLE;
      fe_start <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            work      <= cov_matrix;
            eig_count <= '0;
            error     <= 1'b0;
            wd        <= '0;
            busy      <= 1'b1;
            fe_start  <= 1'b1;
            state     <= RUN;
            for (int k = 0; k < NUM_EIG; k++)
              eigenvalues[k] <= '0;
            for (int i = 0; i < SIZE_N; i++)
              for (int k = 0; k < NUM_EIG; k++)
                eigenvectors[i][k] <= '0;
          end
        end
        RUN: begin
          wd <= wd + WW'(1);
          // completion beats a simultaneous watchdog expiry
          if (fe_valid) begin
            fe_start <= 1'b0;
            state    <= CAPTURE;
          end else if (wd == WW'(MAX_CYCLES - 1)) begin
            error    <= 1'b1;
            done     <= 1'b1;
            fe_start <= 1'b0;
            state    <= DONE;
          end
        end
        CAPTURE: begin
          for (int k = 0; k < NUM_EIG; k++) begin
            if (eig_count == CW'(k)) begin
              eigenvalues[k] <= fe_eigenvalue[0][0];
              for (int i = 0; i < SIZE_N; i++)
                eigenvectors[i][k] <= fe_eigenvector[i][0];
            end
          end
          work      <= fe_cov_matrix_out;
          eig_count <= eig_count + CW'(1);
          gap_cnt   <= '0;
          state     <= GAP;
        end
        GAP: begin
          // fe_start stays low so find_eigen sub-blocks clear
          wd <= '0;
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            if (eig_count < CW'(NUM_EIG)) begin
              fe_start <= 1'b1;
              state    <= RUN;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eigen_deflation_sequencer.sv
// Bench for eigen_deflation_sequencer: stub find_eigen with random pass
// latencies and data, checked against a pass-level reference model.
module tb_eigen_deflation_sequencer;

  localparam int N    = 8;
  localparam int K    = 4;
  localparam int G    = 2;
  localparam int MAXC = 100;
  localparam int CW   = $clog2(K + 1);

  logic          clk = 1'b0;
  logic          clk_en = 1'b1;
  logic          rst, start, abort, fe_valid;
  logic [31:0]   scale, fe_scale;
  logic [63:0]   cov_matrix [N][N];
  logic          fe_start;
  logic [63:0]   fe_cov_matrix [N][N];
  logic [63:0]   fe_eigenvalue [1][1];
  logic [63:0]   fe_eigenvector [N][1];
  logic [63:0]   fe_cov_matrix_out [N][N];
  logic [63:0]   eigenvalues [K];
  logic [63:0]   eigenvectors [N][K];
  logic [CW-1:0] eig_count;
  logic          busy, done, error;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int run_cnt = 0;
  int stub_pass = 0;
  bit inject = 0;
  bit hang = 0;
  int lat [K];
  logic [63:0] mat [K+1][N][N];
  logic [63:0] vec [K][N];

  eigen_deflation_sequencer #(
    .SIZE_N(N), .NUM_EIG(K),
    .GAP_CYCLES(G), .MAX_CYCLES(MAXC)
  ) dut (
    .clk(clk), .rst(rst),
    .start(start), .abort(abort),
    .scale(scale),
    .cov_matrix(cov_matrix),
    .fe_start(fe_start),
    .fe_scale(fe_scale),
    .fe_cov_matrix(fe_cov_matrix),
    .fe_eigenvalue(fe_eigenvalue),
    .fe_eigenvector(fe_eigenvector),
    .fe_cov_matrix_out(fe_cov_matrix_out),
    .fe_valid(fe_valid),
    .eigenvalues(eigenvalues),
    .eigenvectors(eigenvectors),
    .eig_count(eig_count),
    .busy(busy), .done(done),
    .error(error)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one clock; stub find_eigen reacts to what it sees after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    fe_valid = 1'b0;
    if (fe_start) begin
      run_cnt++;
      if (!hang && stub_pass < K && run_cnt == lat[stub_pass]) begin
        fe_valid = 1'b1;
        fe_eigenvalue[0][0] = $realtobits(real'(stub_pass + 1));
        for (int i = 0; i < N; i++) begin
          fe_eigenvector[i][0] = vec[stub_pass][i];
          for (int j = 0; j < N; j++)
            fe_cov_matrix_out[i][j] = mat[stub_pass+1][i][j];
        end
        stub_pass++;
      end
    end else begin
      run_cnt = 0;
      if (inject) fe_valid = 1'b1;
    end
  endtask

  function automatic int cov_bad(int p);
    int b = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (fe_cov_matrix[i][j] !== mat[p][i][j]) b++;
    return b;
  endfunction

  function automatic int cov_nz();
    int b = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (fe_cov_matrix[i][j] !== 64'h0) b++;
    return b;
  endfunction

  // results must hold passes 0..n-1 and zeros beyond
  function automatic int res_bad(int n);
    int b = 0;
    logic [63:0] e;
    for (int k = 0; k < K; k++) begin
      e = (k < n) ? $realtobits(real'(k + 1)) : 64'h0;
      if (eigenvalues[k] !== e) b++;
      for (int i = 0; i < N; i++) begin
        e = (k < n) ? vec[k][i] : 64'h0;
        if (eigenvectors[i][k] !== e) b++;
      end
    end
    return b;
  endfunction

  // mode: 0 normal, 1 hang, 2 spurious start + abort,
  //       3 reset mid-gap, 4 pass latency equal to watchdog
  task automatic run_seq(input int mode);
    int  pidx, hicnt, lowcnt, c0, sumlat, dn;
    bit  prev_fs, fin;
    sumlat = 0;
    for (int p = 0; p < K; p++) begin
      lat[p] = $urandom_range(8, 40);
      if (mode == 4 && p == 1) lat[p] = MAXC;
      sumlat += lat[p];
    end
    for (int p = 0; p <= K; p++)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          mat[p][i][j] = {$urandom, $urandom};
    for (int p = 0; p < K; p++)
      for (int i = 0; i < N; i++)
        vec[p][i] = {$urandom, $urandom};
    cov_matrix = mat[0];
    hang = (mode == 1);
    stub_pass = 0;
    scale = $urandom;
    tick();
    start = 1'b1;
    c0 = cyc;
    pidx = -1;
    hicnt = 0;
    lowcnt = 0;
    prev_fs = 1'b0;
    fin = 1'b0;
    for (int t = 0; t < 3000 && !fin; t++) begin
      tick();
      start = 1'b0;
      if (t == 0) begin
        chk("busy_up", busy, 1);
        chk("err_clr", error, 0);
        chk("cnt_clr", eig_count, 0);
        chk("res_clr", res_bad(0), 0);
        chk("scale", fe_scale, scale);
        // source must already be captured
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            cov_matrix[i][j] = {$urandom, $urandom};
      end
      if (fe_start && !prev_fs) begin
        pidx++;
        hicnt = 0;
        chk("fe_cov", cov_bad(pidx), 0);
        if (pidx > 0) chk("gap_len", lowcnt, G + 1);
      end
      if (!fe_start && prev_fs) begin
        chk("run_len", hicnt, hang ? MAXC : lat[pidx]);
        lowcnt = 0;
      end
      if (fe_start) hicnt++;
      else lowcnt++;
      prev_fs = fe_start;
      if (mode == 2 && pidx == 1 && hicnt == 3)
        start = 1'b1;
      if (mode == 2 && pidx == 2 && hicnt == 5) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_busy", busy, 0);
        chk("ab_fs", fe_start, 0);
        chk("ab_cnt", eig_count, 2);
        chk("ab_err", error, 0);
        chk("ab_res", res_bad(2), 0);
        dn = 0;
        repeat (10) begin
          tick();
          if (done) dn++;
        end
        chk("ab_nodone", dn, 0);
        fin = 1'b1;
      end
      if (mode == 3 && pidx == 0 && !fe_start && lowcnt == 2) begin
        clk_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("ar_fs", fe_start, 0);
        chk("ar_busy", busy, 0);
        chk("ar_done", done, 0);
        chk("ar_err", error, 0);
        chk("ar_cnt", eig_count, 0);
        chk("ar_res", res_bad(0), 0);
        chk("ar_cov", cov_nz(), 0);
        #2 rst = 1'b0;
        #7 clk_en = 1'b1;
        fin = 1'b1;
      end
      if (done) begin
        fin = 1'b1;
        chk("done_cnt", eig_count, hang ? 0 : K);
        chk("done_err", error, hang);
        chk("done_res", res_bad(hang ? 0 : K), 0);
        chk("done_fs", fe_start, 0);
        chk("latency", cyc - c0 + 1,
            hang ? MAXC + 2 : sumlat + K * (1 + G) + 2);
        tick();
        chk("done_pulse", done, 0);
        chk("idle_busy", busy, 0);
      end
    end
    if (!fin) chk("timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    fe_valid = 1'b0;
    scale = '0;
    fe_eigenvalue[0][0] = '0;
    for (int i = 0; i < N; i++) begin
      fe_eigenvector[i][0] = '0;
      for (int j = 0; j < N; j++) begin
        cov_matrix[i][j] = '0;
        fe_cov_matrix_out[i][j] = '0;
      end
    end
    for (int p = 0; p < K; p++) lat[p] = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_fs", fe_start, 0);
    chk("rst_done", done, 0);
    chk("rst_err", error, 0);
    chk("rst_cnt", eig_count, 0);
    chk("rst_res", res_bad(0), 0);
    chk("rst_cov", cov_nz(), 0);
    rst = 1'b0;

    inject = 1'b1;
    run_seq(0);
    repeat (5) tick();
    chk("idle_cnt", eig_count, K);
    chk("idle_res", res_bad(K), 0);
    chk("idle_busy2", busy, 0);
    inject = 1'b0;

    run_seq(4);
    run_seq(1);
    run_seq(2);
    run_seq(0);
    run_seq(3);
    run_seq(0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/eigen_deflation_sequencer.md
Name: eigen_deflation_sequencer

Overview:
- Sequences one find_eigen instance through NUM_EIG power-iteration and deflation passes. Extracts the NUM_EIG dominant eigenpairs of an SIZE_N x SIZE_N covariance matrix.
- After each pass, the deflated matrix returned by find_eigen becomes the working matrix for the next pass.
- Sits between the covariance-estimation stage and the ICA/projection stage of the fetal ECG pipeline.
- Owns find_eigen's level-sensitive start and its clear-on-low behaviour.

Parameters:
- SIZE_N, 8, matrix dimension (channels).
- NUM_EIG, 4, number of eigenpairs to extract; 1..SIZE_N.
- GAP_CYCLES, 2, cycles fe_start is held low between passes so find_eigen sub-blocks clear; minimum 1.
- MAX_CYCLES, 65536, per-pass watchdog limit in clock cycles.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- abort  in  1  returns the block to IDLE from any state.
- scale  in  32 (integer)  passed unchanged to find_eigen scale.
- cov_matrix  in  double[SIZE_N][SIZE_N]  source matrix, captured on accepted start.
- fe_start  out  1  level start to find_eigen.
- fe_cov_matrix  out  double[SIZE_N][SIZE_N]  working matrix driven to find_eigen.
- fe_eigenvalue  in  double[1][1]  from find_eigen.
- fe_eigenvector  in  double[SIZE_N][1]  from find_eigen.
- fe_cov_matrix_out  in  double[SIZE_N][SIZE_N]  deflated matrix from find_eigen.
- fe_valid  in  1  find_eigen completion pulse.
- eigenvalues  out  double[NUM_EIG]  extracted eigenvalues, index 0 = first pass.
- eigenvectors  out  double[SIZE_N][NUM_EIG]  column k = eigenvector of pass k.
- eig_count  out  $clog2(NUM_EIG+1)  passes completed.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- error  out  1  watchdog expired; sticky.

Behaviour:
- Reset (async, rst=1) drives every output and register to 0 and enters IDLE: fe_start, busy, done, error, eig_count, eigenvalues, eigenvectors, fe_cov_matrix, working matrix.
- States: IDLE, RUN, CAPTURE, GAP, DONE.
- IDLE, start=1:
  - working matrix <= cov_matrix; eigenvalues/eigenvectors <= 0; eig_count <= 0; error <= 0; watchdog <= 0.
  - Next state RUN. busy rises the cycle after start.
- start while busy is ignored; no queueing.
- RUN:
  - fe_start=1 and held continuously; fe_cov_matrix = working matrix, stable for the entire pass.
  - Watchdog increments each cycle.
  - fe_valid=1 -> CAPTURE.
  - Watchdog reaching MAX_CYCLES with no fe_valid -> error<=1, then DONE.
  - If fe_valid and the watchdog limit occur on the same cycle, fe_valid wins.
- CAPTURE (1 cycle):
  - eigenvalues[eig_count] <= fe_eigenvalue[0][0].
  - eigenvectors[*][eig_count] <= fe_eigenvector[*][0].
  - working matrix <= fe_cov_matrix_out; eig_count++.
  - fe_start=0 from this cycle onward. Next state GAP.
- GAP:
  - fe_start=0 for exactly GAP_CYCLES cycles; watchdog <= 0.
  - Then RUN if eig_count<NUM_EIG, else DONE.
- DONE: done=1 for exactly one cycle; busy=0 from the next cycle; next state IDLE. Results hold until the next accepted start.
- fe_valid outside RUN is ignored.
- abort (any non-IDLE state) -> fe_start<=0, IDLE next cycle.
  - done is not pulsed; error is unchanged.
  - eig_count and results keep the completed passes.
- Latency: total = sum of find_eigen pass latencies + NUM_EIG*(1+GAP_CYCLES) + 2 cycles.
- No arithmetic on double data; captures are bit-exact copies.

Test Plan:
- Diagonal SIZE_N=8 matrix, diag 8.0..1.0, NUM_EIG=4, real find_eigen:
  - eigenvalues = 8.0, 7.0, 6.0, 5.0 (within 1e-6).
  - eigenvectors = unit vectors e0..e3 (sign free).
  - eig_count=4, single done pulse, error=0.
- Stub find_eigen returning fe_valid 50 cycles after fe_start rises, with eigenvalue=pass index+1:
  - fe_start low exactly GAP_CYCLES+1 cycles between passes.
  - fe_cov_matrix updated to stub's fe_cov_matrix_out before each RUN.
  - done asserted exactly 4*(50+1+2)+2 cycles after start (+/-0 per stub alignment).
- Stub never asserts fe_valid, MAX_CYCLES=100:
  - error=1 after 100 RUN cycles, done pulses, eig_count=0, fe_start=0, block returns to IDLE.
- start pulsed during pass 2: ignored. abort during pass 3: IDLE next cycle, eig_count=2, no done. New start afterwards: error and results cleared, full run completes.
- rst asserted mid-GAP with clk stopped: all outputs 0 immediately, without a clock edge. After release, start runs normally.
- fe_valid asserted while in GAP/IDLE: no capture, eig_count unchanged.
